expand_fetch_ctrl: RTL

//  Parametrised fetch/align controller for expand convolution: issues lockstep requests to the layer source and N kernel RAMs.

---
 rtl/expand_pkg.sv | 28 ++
 rtl/expand_fetch_ctrl_if.sv | 65 ++++++
 rtl/pipe_delay.sv | 38 +++
 rtl/expand_fetch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/expand_pkg.sv
// ----------------------------------------------------------------------------
// expand_pkg
// Shared definitions for the expand-convolution fetch/align controller:
//   - state_e       : run sequencer states (IDLE, RUN, DRAIN, DONE)
//   - DEF_FIFO_TH   : default downstream FIFO headroom threshold
//   - DEF_LW/DEF_KW : default layer / kernel stream widths
//   - alignDepth()  : beat-to-output latency for a pair of read latencies
// ----------------------------------------------------------------------------
package expand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_FIFO_TH = 230;
    localparam int DEF_LW      = 72;
    localparam int DEF_KW      = 72;

    // Both streams are re-timed so they leave together one cycle after the
    // slower of the two sources delivers its word.
    function automatic int alignDepth(input int layerLat, input int kerLat);
        return ((layerLat > kerLat) ? layerLat : kerLat) + 1;
    endfunction

endpackage

// File: rtl/expand_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// expand_fetch_ctrl_if
// Bundles the source, backpressure and downstream beat signals of the
// expand fetch controller.
//   master : controller side (drives requests and the aligned beat)
//   slave  : environment side (layer source, kernel RAMs, FIFOs, conv cores)
// Signals:
//   layer_req_o / layer_ready_i / layer_data_i  layer source handshake + data
//   ker_req_o   / ker_ready_i   / ker_data_i    kernel RAM handshake + data
//   fifo_count_i                                downstream FIFO data counts
//   layer_data_o, ker_data_o, data_valid_o,
//   group_last_o, run_last_o                    aligned beat to conv cores
// ----------------------------------------------------------------------------
interface expand_fetch_ctrl_if #(
    parameter int LW       = 72,
    parameter int NUM_KER  = 5,
    parameter int KW       = 72,
    parameter int NUM_FIFO = 2,
    parameter int FCW      = 8
);

    logic                     layer_req_o;
    logic                     layer_ready_i;
    logic [LW-1:0]            layer_data_i;
    logic                     ker_req_o;
    logic                     ker_ready_i;
    logic [NUM_KER*KW-1:0]    ker_data_i;
    logic [NUM_FIFO*FCW-1:0]  fifo_count_i;
    logic [LW-1:0]            layer_data_o;
    logic [NUM_KER*KW-1:0]    ker_data_o;
    logic                     data_valid_o;
    logic                     group_last_o;
    logic                     run_last_o;

    modport master (
        output layer_req_o,
        input  layer_ready_i,
        input  layer_data_i,
        output ker_req_o,
        input  ker_ready_i,
        input  ker_data_i,
        input  fifo_count_i,
        output layer_data_o,
        output ker_data_o,
        output data_valid_o,
        output group_last_o,
        output run_last_o
    );

    modport slave (
        input  layer_req_o,
        output layer_ready_i,
        output layer_data_i,
        input  ker_req_o,
        output ker_ready_i,
        output ker_data_i,
        output fifo_count_i,
        input  layer_data_o,
        input  ker_data_o,
        input  data_valid_o,
        input  group_last_o,
        input  run_last_o
    );

endinterface

// File: rtl/pipe_delay.sv
// ----------------------------------------------------------------------------
// pipe_delay
// Fixed-length register delay line with asynchronous active-low reset.
// Ports:
//   clk_i   in  1      clock, rising edge
//   rst_n_i in  1      asynchronous reset, active low (clears every stage)
//   din_i   in  W      value entering the line
//   dout_o  out W      din_i delayed by DEPTH cycles (DEPTH >= 1)
// ----------------------------------------------------------------------------
module pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Plain shift register; the line never stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/expand_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// expand_fetch_ctrl
// Fetch/align controller for expand convolution. Issues lockstep requests to
// the layer source and the kernel RAMs, reuses each layer word for
// ker_reuse_i kernel beats, throttles on downstream FIFO fill level and
// re-times the two read streams so every beat leaves as one aligned word.
// Ports:
//   clk_i          in   clock, rising edge
//   rst_n_i        in   asynchronous reset, active low
//   start_i        in   1-cycle pulse; latches config and starts a run (IDLE only)
//   ker_reuse_i    in   kernel beats per layer word (0 treated as 1)
//   layer_words_i  in   layer words in the run (0 -> immediate done)
//   busy_o         out  high from accepted start until done_o
//   done_o         out  1-cycle pulse once the run's last beat has left
//   bus            master side of expand_fetch_ctrl_if (requests, source
//                  data, FIFO counts, aligned beat outputs)
// ----------------------------------------------------------------------------
module expand_fetch_ctrl
    import expand_pkg::*;
#(
    parameter int LW        = DEF_LW,
    parameter int NUM_KER   = 5,
    parameter int KW        = DEF_KW,
    parameter int NUM_FIFO  = 2,
    parameter int FCW       = 8,
    parameter int FIFO_TH   = DEF_FIFO_TH,
    parameter int LAYER_LAT = 1,
    parameter int KER_LAT   = 1,
    parameter int RW        = 7,
    parameter int CW        = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [RW-1:0]          ker_reuse_i,
    input  logic [CW-1:0]          layer_words_i,
    output logic                   busy_o,
    output logic                   done_o,
    expand_fetch_ctrl_if.master    bus
);

    localparam int         ALIGN_D    = alignDepth(LAYER_LAT, KER_LAT);
    localparam logic [2:0] DRAIN_LOAD = 3'(ALIGN_D - 1);
    localparam int         KDW        = NUM_KER * KW;

    state_e          state_q, state_d;
    logic [RW-1:0]   reuse_q, reuse_d;
    logic [CW-1:0]   words_q, words_d;
    logic [RW-1:0]   repCnt_q, repCnt_d;
    logic [CW-1:0]   wordCnt_q, wordCnt_d;
    logic [2:0]      drainCnt_q, drainCnt_d;
    logic            fifoOk_q, fifoOk_d;

    logic            beat;
    logic            groupLast;
    logic            runLast;

    logic [2:0]      alignFlags;
    logic [LW-1:0]   alignLayer;
    logic [KDW-1:0]  alignKer;
    logic            alignValid;

    logic [LW-1:0]   heldLayer_q;
    logic [KDW-1:0]  heldKer_q;
    logic            heldGroupLast_q;
    logic            heldRunLast_q;

    // FIFO headroom is judged on last cycle's counts; the threshold leaves
    // room for the beats already in flight when a FIFO crosses it.
    always_comb begin
        fifoOk_d = 1'b1;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (bus.fifo_count_i[i*FCW +: FCW] >= FCW'(FIFO_TH)) begin
                fifoOk_d = 1'b0;
            end
        end
    end

    assign groupLast = (repCnt_q == reuse_q - RW'(1));
    assign runLast   = groupLast && (wordCnt_q == words_q - CW'(1));
    assign beat      = (state_q == RUN) && bus.layer_ready_i && bus.ker_ready_i && fifoOk_q;

    assign bus.ker_req_o   = beat;
    assign bus.layer_req_o = beat && groupLast;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

    // Sequencer next state and counter updates.
    always_comb begin
        state_d    = state_q;
        reuse_d    = reuse_q;
        words_d    = words_q;
        repCnt_d   = repCnt_q;
        wordCnt_d  = wordCnt_q;
        drainCnt_d = drainCnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    reuse_d   = (ker_reuse_i == '0) ? RW'(1) : ker_reuse_i;
                    words_d   = layer_words_i;
                    repCnt_d  = '0;
                    wordCnt_d = '0;
                    state_d   = (layer_words_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    if (groupLast) begin
                        repCnt_d  = '0;
                        wordCnt_d = wordCnt_q + CW'(1);
                    end else begin
                        repCnt_d  = repCnt_q + RW'(1);
                    end
                    if (runLast) begin
                        state_d    = DRAIN;
                        drainCnt_d = DRAIN_LOAD;
                    end
                end
            end
            // No beats issue after RUN, so the pipe is empty exactly
            // ALIGN_D cycles after the final beat.
            DRAIN: begin
                if (drainCnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, latched configuration and FIFO headroom flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            reuse_q    <= '0;
            words_q    <= '0;
            repCnt_q   <= '0;
            wordCnt_q  <= '0;
            drainCnt_q <= '0;
            fifoOk_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            reuse_q    <= reuse_d;
            words_q    <= words_d;
            repCnt_q   <= repCnt_d;
            wordCnt_q  <= wordCnt_d;
            drainCnt_q <= drainCnt_d;
            fifoOk_q   <= fifoOk_d;
        end
    end

    // Each stream waits out the difference between its read latency and the
    // common alignment depth; the flags ride the full depth from the beat.
    pipe_delay #(.W(3), .DEPTH(ALIGN_D)) u_flagPipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .din_i   ({beat, groupLast, runLast}),
        .dout_o  (alignFlags)
    );

    pipe_delay #(.W(LW), .DEPTH(ALIGN_D - LAYER_LAT)) u_layerPipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .din_i   (bus.layer_data_i),
        .dout_o  (alignLayer)
    );

    pipe_delay #(.W(KDW), .DEPTH(ALIGN_D - KER_LAT)) u_kerPipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .din_i   (bus.ker_data_i),
        .dout_o  (alignKer)
    );

    assign alignValid = alignFlags[2];

    // Remember the last valid beat so the outputs hold between beats.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            heldLayer_q     <= '0;
            heldKer_q       <= '0;
            heldGroupLast_q <= 1'b0;
            heldRunLast_q   <= 1'b0;
        end else if (alignValid) begin
            heldLayer_q     <= alignLayer;
            heldKer_q       <= alignKer;
            heldGroupLast_q <= alignFlags[1];
            heldRunLast_q   <= alignFlags[0];
        end
    end

    assign bus.data_valid_o = alignValid;
    assign bus.layer_data_o = alignValid ? alignLayer    : heldLayer_q;
    assign bus.ker_data_o   = alignValid ? alignKer      : heldKer_q;
    assign bus.group_last_o = alignValid ? alignFlags[1] : heldGroupLast_q;
    assign bus.run_last_o   = alignValid ? alignFlags[0] : heldRunLast_q;

endmodule
